// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: response owner tags, owner FIFO entries
// and the address window helper used to decide whether a request reaches memory.
package mem_port_arbiter_pkg;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  typedef struct packed {
    owner_e owner;
    logic   err;
  } fifo_entry_t;

  localparam logic [3:0] FULL_BE = 4'hF;

  // Widened to 33 bits so a window ending exactly at 4 GiB does not wrap.
  function automatic logic addr_in_range(logic [31:0] addr, logic [31:0] base,
                                         int unsigned words);
    logic [32:0] lo;
    logic [32:0] hi;
    logic [32:0] a;
    lo = {1'b0, base};
    hi = lo + (33'(words) << 2);
    a  = {1'b0, addr};
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/arb_owner_fifo.sv
// Small FIFO recording which port owns each outstanding response, in grant order.
// A push and a pop in the same cycle are accepted at any occupancy, including full.
module arb_owner_fifo
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  fifo_entry_t push_entry,
  input  logic        pop,
  output fifo_entry_t head,
  output logic        empty,
  output logic        full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  fifo_entry_t      entries [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = entries[rd_ptr];

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      entries[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the core's instruction
// and data ports; out-of-window accesses are answered locally with an error response.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter logic [31:0] MEM_BASE        = 32'h0000_0000,
  parameter int unsigned MEM_WORDS       = 256,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  owner_e      last_winner;
  owner_e      winner;
  logic        any_req;
  logic [31:0] win_addr;
  logic        win_in_range;
  logic        win_gnt;
  logic        resp_valid;
  fifo_entry_t push_entry;
  fifo_entry_t head;
  logic        fifo_empty;
  logic        fifo_full;

  // Pick the winner, then decide whether it can be granted this cycle.
  always_comb begin
    any_req = instr_req_i | data_req_i;
    if (instr_req_i && data_req_i) begin
      winner = (last_winner == OWNER_DATA) ? OWNER_INSTR : OWNER_DATA;
    end else if (data_req_i) begin
      winner = OWNER_DATA;
    end else begin
      winner = OWNER_INSTR;
    end
    win_addr     = (winner == OWNER_DATA) ? data_addr_i : instr_addr_i;
    win_in_range = addr_in_range(win_addr, MEM_BASE, MEM_WORDS);
    // Local error responses wait for an empty FIFO so they can never overtake memory data.
    win_gnt      = rst_ni && any_req && !fifo_full &&
                   (win_in_range ? mem_gnt_i : fifo_empty);
    push_entry   = '{owner: winner, err: !win_in_range};
  end

  always_comb begin
    mem_req_o   = rst_ni && any_req && win_in_range && !fifo_full;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (any_req) begin
      mem_addr_o = win_addr;
      if (winner == OWNER_DATA) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o = FULL_BE;
      end
    end
  end

  assign instr_gnt_o = win_gnt && (winner == OWNER_INSTR);
  assign data_gnt_o  = win_gnt && (winner == OWNER_DATA);

  // Stray mem_rvalid_i with nothing outstanding falls through here harmlessly.
  always_comb begin
    resp_valid     = !fifo_empty && (head.err || mem_rvalid_i);
    instr_rvalid_o = resp_valid && (head.owner == OWNER_INSTR);
    data_rvalid_o  = resp_valid && (head.owner == OWNER_DATA);
    instr_err_o    = instr_rvalid_o && head.err;
    data_err_o     = data_rvalid_o && head.err;
    instr_rdata_o  = (instr_rvalid_o && !head.err) ? mem_rdata_i : '0;
    data_rdata_o   = (data_rvalid_o && !head.err) ? mem_rdata_i : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_winner <= OWNER_DATA;
    end else if (win_gnt) begin
      last_winner <= winner;
    end
  end

  arb_owner_fifo #(
    .DEPTH(int'(MAX_OUTSTANDING))
  ) u_owner_fifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .push      (win_gnt),
    .push_entry(push_entry),
    .pop       (resp_valid),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule
